fa_serial_alu_ctrl: RTL and testbench

- Sequencer that time-multiplexes one FullAdder instance into a WIDTH-bit add/subtract unit, one bit per clock, LSB first.
- Area-minimal arithmetic for slow-path uses: CSR counter updates, multi-cycle address calculation, self-test.
- Start/busy/done handshake; registered result plus carry, signed-overflow and zero flags.

---
 rtl/fa_serial_alu_ctrl.sv | 152 +++++++++++++++
 tb/tb_fa_serial_alu_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fa_serial_alu_ctrl.sv
// Bit-serial add/subtract unit: one full adder reused for each bit, LSB first, one bit per clock.
// Start/busy/done handshake with a registered result and carry, signed-overflow and zero flags.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module fa_serial_alu_ctrl #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MSB_IDX  = CW'(WIDTH - 2);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    idx;
    logic             carry;
    logic             cin_msb;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .a    (op_a[idx]),
        .b    (op_b[idx]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (idx == LAST_IDX);

    always_comb begin
        res_nxt      = res_q;
        res_nxt[idx] = fa_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is folded into the operands: invert B once and seed the carry with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            res_q   <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            cin_msb <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a    <= a;
                        op_b    <= sub ? ~b : b;
                        carry   <= sub;
                        idx     <= '0;
                        res_q   <= '0;
                        cin_msb <= 1'b0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        zero_q  <= 1'b0;
                    end
                end
                RUN: begin
                    res_q <= res_nxt;
                    carry <= fa_cout;
                    idx   <= idx + CW'(1);
                    if (idx == MSB_IDX) begin
                        cin_msb <= fa_cout;
                    end
                    // Overflow is carry-into-MSB xor carry-out-of-MSB.
                    if (last_bit) begin
                        cout_q <= fa_cout;
                        ovf_q  <= cin_msb ^ fa_cout;
                        zero_q <= (res_nxt == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result   = res_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_fa_serial_alu_ctrl.sv
// Directed bench for the bit-serial add/subtract unit at WIDTH=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_fa_serial_alu_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         zero;

    int checks = 0;
    int errors = 0;

    fa_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, cout, result}, built from full-width arithmetic and sign rules.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         ov;
        full = s ? ({1'b0, x} + {1'b0, ~y} + 1) : ({1'b0, x} + {1'b0, y});
        r    = full[W-1:0];
        if (s) ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        else   ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        return {ov, full[W], r};
    endfunction

    // One operation from IDLE: checks latency, busy length and all flags.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, input logic [W-1:0] er, input logic ec,
                          input logic eo, input logic ez);
        int busy_cnt;
        int done_cyc;
        busy_cnt = 0;
        done_cyc = -1;
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        chk({tag, "_done_cycle"}, done_cyc, 9);
        chk({tag, "_busy_cycles"}, busy_cnt, 8);
        chk({tag, "_result"}, result, er);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_overflow"}, overflow, eo);
        chk({tag, "_zero"}, zero, ez);
    endtask

    initial begin
        logic [W+1:0] exp_v;
        logic [W-1:0] prev_res;
        logic         prev_c;
        logic         prev_o;
        int done_cnt;
        int busy_cnt;
        int done_cyc;
        int cyc;
        int last;
        int ops;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_cout", cout, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_zero", zero, 0);

        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_07_05", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

        // Second start mid-run with churning operands must be ignored.
        @(negedge clk);
        a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
        done_cnt = 0; busy_cnt = 0; done_cyc = -1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 8 && busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    prev_res = result;
                end
            end
            start = (c == 3);
            if (c == 3) begin
                a = 8'hFF; b = 8'hFF;
            end else begin
                a = W'($urandom); b = W'($urandom);
            end
        end
        start = 1'b0;
        chk("ignore_done_count", done_cnt, 1);
        chk("ignore_done_cycle", done_cyc, 9);
        chk("ignore_busy_steady", busy_cnt, 8);
        chk("ignore_result", prev_res, 8'h30);
        chk("ignore_idle_after", busy, 0);

        // Reset mid-run aborts without a done pulse.
        @(negedge clk);
        a = 8'h55; b = 8'h55; sub = 1'b0; start = 1'b1;
        done_cnt = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done) done_cnt++;
            if (c == 3) rst = 1'b1;
        end
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_cout", cout, 0);
        chk("abort_overflow", overflow, 0);
        chk("abort_zero", zero, 0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        run_op("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

        // Continuous start: one operation every WIDTH+2 cycles.
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); start = 1'b1;
        exp_v = model(a, b, sub);
        cyc = 0; last = -1; ops = 0;
        while (ops < 200 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                chk("rand_result", result, exp_v[W-1:0]);
                chk("rand_cout", cout, exp_v[W]);
                chk("rand_overflow", overflow, exp_v[W+1]);
                chk("rand_zero", zero, (exp_v[W-1:0] == '0));
                if (last >= 0) chk("rand_interval", cyc - last, 10);
                last = cyc;
                ops++;
                prev_res = result; prev_c = cout; prev_o = overflow;
                a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
                exp_v = model(a, b, sub);
                if (ops == 200) start = 1'b0;
                @(negedge clk);
                cyc++;
                chk("rand_idle_busy", busy, 0);
                chk("rand_idle_done", done, 0);
                chk("rand_idle_result", result, prev_res);
                chk("rand_idle_cout", cout, prev_c);
                chk("rand_idle_overflow", overflow, prev_o);
            end
        end
        start = 1'b0;
        chk("rand_ops_completed", ops, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
